// File: rtl/dircc_processing_mem_port_arbiter_if.sv
// Bus bundle between the two Avalon-MM masters (rx/tx network engines),
// the port-B arbiter and the 16-bit port of the processing memory.
interface dircc_processing_mem_port_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);
    // master 0: network receive engine
    logic [ADDR_W-1:0] m0_address;
    logic              m0_read;
    logic              m0_write;
    logic [DATA_W-1:0] m0_writedata;
    logic [1:0]        m0_byteenable;
    logic              m0_waitrequest;
    logic [DATA_W-1:0] m0_readdata;
    logic              m0_readdatavalid;

    // master 1: network send engine
    logic [ADDR_W-1:0] m1_address;
    logic              m1_read;
    logic              m1_write;
    logic [DATA_W-1:0] m1_writedata;
    logic [1:0]        m1_byteenable;
    logic              m1_waitrequest;
    logic [DATA_W-1:0] m1_readdata;
    logic              m1_readdatavalid;

    // memory port B
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic [1:0]        mem_byteenable;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    // arbiter side
    modport slave (
        input  m0_address, m0_read, m0_write, m0_writedata, m0_byteenable,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output mem_address, mem_chipselect, mem_write, mem_writedata,
        output mem_byteenable, mem_clken,
        input  mem_readdata
    );

    // masters plus memory side
    modport master (
        output m0_address, m0_read, m0_write, m0_writedata, m0_byteenable,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  mem_address, mem_chipselect, mem_write, mem_writedata,
        input  mem_byteenable, mem_clken,
        output mem_readdata
    );
endinterface

// File: rtl/dircc_processing_mem_port_arbiter.sv
// Two-master round-robin arbiter for the 16-bit port B of processing memory.
// One access per clock; reads return with a fixed two-cycle latency through
// a one-stage tracking pipeline. Out-of-range and read+write requests are
// accepted but flagged in a sticky error bit.
module dircc_processing_mem_port_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 16,
    parameter int NUMWORDS = 15000
) (
    input  logic                               clk,
    input  logic                               reset_n,
    dircc_processing_mem_port_arbiter_if.slave bus,
    output logic                               err_sticky,
    input  logic                               err_clear
);
    localparam int              NUM_LANES = 2;
    localparam logic [ADDR_W:0] LIMIT     = (ADDR_W + 1)'(NUMWORDS);

    // per-master request view, lane k = master k
    logic [NUM_LANES-1:0]             rd, wr, req, grant, wait_r;
    logic [NUM_LANES-1:0][ADDR_W-1:0] addr;
    logic [NUM_LANES-1:0][DATA_W-1:0] wdata;
    logic [NUM_LANES-1:0][1:0]        be;

    assign rd    = {bus.m1_read, bus.m0_read};
    assign wr    = {bus.m1_write, bus.m0_write};
    assign addr  = {bus.m1_address, bus.m0_address};
    assign wdata = {bus.m1_writedata, bus.m0_writedata};
    assign be    = {bus.m1_byteenable, bus.m0_byteenable};
    assign req   = rd | wr;

    logic rr_last_d, rr_last_q;
    logic err_d, err_q;
    // read-tracking stage: {valid, master id, out_of_range}
    logic s1_vld_d, s1_vld_q;
    logic s1_id_d, s1_id_q;
    logic s1_oor_d, s1_oor_q;

    logic              gid, any_gnt, in_range, both_rw;
    logic              mem_cs, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_be;

    logic [NUM_LANES-1:0]             rdv_d, rdv_q;
    logic [NUM_LANES-1:0][DATA_W-1:0] rdata_d, rdata_q;

    // grant, memory command, error and read-tracking next state
    always_comb begin
        grant = '0;
        if (reset_n) begin
            if (req[0] && req[1]) grant = rr_last_q ? 2'b01 : 2'b10;
            else                  grant = req;
        end
        gid      = grant[1];
        any_gnt  = |grant;
        in_range = {1'b0, addr[gid]} < LIMIT;
        both_rw  = rd[gid] & wr[gid];

        // out-of-range accesses are accepted but never reach the memory
        mem_cs    = any_gnt & in_range;
        mem_we    = mem_cs & wr[gid];
        mem_addr  = mem_cs ? addr[gid]  : '0;
        mem_wdata = mem_cs ? wdata[gid] : '0;
        mem_be    = mem_cs ? be[gid]    : '0;

        rr_last_d = any_gnt ? gid : rr_last_q;

        // set wins over clear
        err_d = err_q;
        if (any_gnt && (!in_range || both_rw)) err_d = 1'b1;
        else if (err_clear)                    err_d = 1'b0;

        // read+write counts as a write: no read return
        s1_vld_d = any_gnt & rd[gid] & ~wr[gid];
        s1_id_d  = gid;
        s1_oor_d = ~in_range;
    end

    // return stage: steer registered memory data to the issuing master only
    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            rdv_d[k]   = s1_vld_q && (s1_id_q == 1'(k));
            rdata_d[k] = rdata_q[k];
            if (rdv_d[k]) rdata_d[k] = s1_oor_q ? '0 : bus.mem_readdata;
        end
    end

    // arbiter state and read-tracking stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_last_q <= 1'b1;
            err_q     <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_id_q   <= 1'b0;
            s1_oor_q  <= 1'b0;
        end else begin
            rr_last_q <= rr_last_d;
            err_q     <= err_d;
            s1_vld_q  <= s1_vld_d;
            s1_id_q   <= s1_id_d;
            s1_oor_q  <= s1_oor_d;
        end
    end

    // per-master read data / valid registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdv_q   <= '0;
            rdata_q <= '0;
        end else begin
            rdv_q   <= rdv_d;
            rdata_q <= rdata_d;
        end
    end

    // losers stall; everyone stalls while in reset
    assign wait_r = ~{NUM_LANES{reset_n}} | (req & ~grant);

    assign bus.m0_waitrequest   = wait_r[0];
    assign bus.m1_waitrequest   = wait_r[1];
    assign bus.m0_readdata      = rdata_q[0];
    assign bus.m1_readdata      = rdata_q[1];
    assign bus.m0_readdatavalid = rdv_q[0];
    assign bus.m1_readdatavalid = rdv_q[1];

    assign bus.mem_address    = mem_addr;
    assign bus.mem_chipselect = mem_cs;
    assign bus.mem_write      = mem_we;
    assign bus.mem_writedata  = mem_wdata;
    assign bus.mem_byteenable = mem_be;
    assign bus.mem_clken      = 1'b1;

    assign err_sticky = err_q;
endmodule
